mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Load/store sequencer directly upstream of the 256x8 data memory, which has a combinational read and a write on the CLK posedge when write-enable is high.
- Accepts single-byte LOAD/STORE and multi-byte COPY requests from the core over a valid/ready handshake.
- Drives the memory's addr/data/write-enable pins and returns load data and a completion pulse.

Parameters:
AW, 8, address width; memory depth 2**AW, all address arithmetic modulo 2**AW
DW, 8, data width
LW, 8, COPY length width; max length 2**LW-1 bytes

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept (high only in IDLE)
req_op  in  2  0=LOAD 1=STORE 2=COPY 3=FILL
req_addr  in  AW  LOAD/STORE address; COPY source; FILL destination
req_addr2  in  AW  COPY destination
req_len  in  LW  COPY/FILL byte count
req_wdata  in  DW  STORE/FILL data
resp_valid  out  1  one-cycle pulse: resp_data valid (LOAD only)
resp_data  out  DW  load result, held until next LOAD completes
done  out  1  one-cycle pulse at completion of any op
err  out  1  one-cycle pulse with done for an unsupported op
mem_addr  out  AW  to data memory addr_in
mem_wdata  out  DW  to data memory data_in
mem_we  out  1  to data memory writemem_ctrl
mem_rdata  in  DW  from data memory data_out (combinational)

Behaviour:
- Reset: state=IDLE; req_ready=1; resp_valid, done, err, mem_we = 0; resp_data, mem_addr, mem_wdata, counters = 0.
- mem_we is combinationally gated with ~RST, so no write commits on a reset edge.
- Handshake: a request is accepted on a posedge with req_valid & req_ready. All req_* fields are registered at acceptance. req_ready=0 in every state except IDLE. Inputs are ignored while busy.
- FSM states: IDLE, LOAD, STORE, CP_RD, CP_WR, FILL, FIN.
- LOAD (accepted at edge N):
  - Cycle N..N+1: state LOAD, mem_addr=addr, mem_we=0.
  - Edge N+1: mem_rdata latched into resp_data; go to FIN.
  - Cycle N+1..N+2: resp_valid=1, done=1; return to IDLE. Latency 2 edges.
- STORE: state STORE drives mem_addr, mem_wdata, mem_we=1 for exactly one cycle. Memory commits at edge N+1. FIN follows, with done=1.
- COPY, len>0:
  - CP_RD latches mem_rdata[src] into an internal byte buffer.
  - CP_WR drives mem_addr=dst, mem_wdata=buffer, mem_we=1.
  - After each write: src+1, dst+1 (both wrap modulo 2**AW), remaining-1.
  - When remaining reaches 0, go to FIN. Total 2*len+1 cycles to the done pulse.
  - Copy order is ascending byte-by-byte: an overlapping dst>src copy propagates bytes (memmove is not guaranteed).
- COPY or FILL with len=0: go directly to FIN, no memory write, done after 1 cycle.
- Unsupported op: go to FIN with done=1, err=1, no memory access.
- FIN always returns to IDLE. A back-to-back request can be accepted on the edge leaving FIN+1 (IDLE).
- RST mid-operation: abort immediately. Remaining bytes are not written; no done pulse.
- resp_data is unchanged by STORE, COPY, and FILL.

Optional Feature:
- Macro MAU_FILL_EN.
- Defined: op 3 (FILL) writes req_wdata to len consecutive bytes starting at req_addr, wrapping. One write per cycle (state FILL, mem_we=1 each cycle), then FIN. Total len+1 cycles.
- Undefined: op 3 is unsupported. It produces done=1 and err=1 with no memory write. FILL state logic is not compiled.

Decomposition:
- Package mau_pkg: mau_op_e enum (LOAD, STORE, COPY, FILL), mau_state_e enum, default AW/DW/LW localparams.
- Sub-module: none. The FSM, address counters and byte buffer fit naturally in one module.
- The bench instantiates mem_access_unit wired to data_mem.

Test Plan:
- Reset then STORE addr=0x10 data=0x5A -> mem_we high for exactly 1 cycle, mem[0x10]=0x5A; done one cycle after the write edge; err=0.
- LOAD addr=0x10 after the above -> resp_valid and done pulse 2 edges after acceptance; resp_data=0x5A; req_ready low for 2 cycles.
- COPY src=0xFE dst=0x20 len=3 over mem[0xFE,0xFF,0x00]=0x11,0x22,0x33 -> mem[0x20..0x22]=0x11,0x22,0x33 (source wraps); done at cycle 7 after acceptance.
- COPY len=0, and (without MAU_FILL_EN) op=3 -> done after 1 cycle, no mem_we; err=1 only for op=3.
- COPY len=5, RST asserted during the 2nd CP_WR -> only the first byte is written; no write at the reset edge; outputs return to reset values; next LOAD works.
- With MAU_FILL_EN: FILL addr=0x40 len=4 data=0xA5 -> mem[0x40..0x43]=0xA5, mem_we high 4 consecutive cycles, done on cycle 5.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared types and default sizes for the memory access unit.
//   mau_op_e    : request opcode encoding on req_op
//   mau_state_e : sequencer states
package mau_pkg;

  localparam int unsigned MAU_AW = 8;
  localparam int unsigned MAU_DW = 8;
  localparam int unsigned MAU_LW = 8;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_COPY  = 2'd2,
    OP_FILL  = 2'd3
  } mau_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE,
    ST_CP_RD,
    ST_CP_WR,
    ST_FILL,
    ST_FIN
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a 256x8 data memory (combinational read,
// write on CLK posedge while mem_we is high).
// Accepts LOAD / STORE / COPY (and FILL when MAU_FILL_EN is defined) requests
// over req_valid/req_ready, drives the memory pins and reports completion.
// Ports:
//   CLK, RST                : clock, synchronous active-high reset
//   req_valid/req_ready     : request handshake (ready only in IDLE)
//   req_op/addr/addr2/len/wdata : request fields, registered at acceptance
//   resp_valid/resp_data    : LOAD result pulse / held load data
//   done, err               : completion pulse, unsupported-op pulse
//   mem_addr/wdata/we/rdata : data memory interface
// Config macro: MAU_FILL_EN enables op 3 (FILL); otherwise op 3 reports err.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned AW = MAU_AW,
  parameter int unsigned DW = MAU_DW,
  parameter int unsigned LW = MAU_LW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_addr2,
  input  logic [LW-1:0] req_len,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_data,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  mau_state_e    state;
  logic          we_q;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [LW-1:0] rem;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] byte_buf;

  // Gate with RST so an abort never commits a write on the reset edge.
  assign mem_we    = we_q & ~RST;
  assign mem_wdata = (state == ST_CP_WR) ? byte_buf : wdata_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      we_q       <= 1'b0;
      mem_addr   <= '0;
      wdata_q    <= '0;
      src        <= '0;
      dst        <= '0;
      rem        <= '0;
      byte_buf   <= '0;
    end else begin
      resp_valid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            src       <= req_addr;
            dst       <= req_addr2;
            rem       <= req_len;
            wdata_q   <= req_wdata;
            case (mau_op_e'(req_op))
              OP_LOAD: begin
                state    <= ST_LOAD;
                mem_addr <= req_addr;
              end
              OP_STORE: begin
                state    <= ST_STORE;
                mem_addr <= req_addr;
                we_q     <= 1'b1;
              end
              OP_COPY: begin
                if (req_len == '0) begin
                  state <= ST_FIN;
                  done  <= 1'b1;
                end else begin
                  state    <= ST_CP_RD;
                  mem_addr <= req_addr;
                end
              end
`ifdef MAU_FILL_EN
              OP_FILL: begin
                if (req_len == '0) begin
                  state <= ST_FIN;
                  done  <= 1'b1;
                end else begin
                  state    <= ST_FILL;
                  mem_addr <= req_addr;
                  we_q     <= 1'b1;
                end
              end
`endif
              default: begin
                state <= ST_FIN;
                done  <= 1'b1;
                err   <= 1'b1;
              end
            endcase
          end
        end
        ST_LOAD: begin
          resp_data  <= mem_rdata;
          resp_valid <= 1'b1;
          done       <= 1'b1;
          state      <= ST_FIN;
        end
        ST_STORE: begin
          we_q  <= 1'b0;
          done  <= 1'b1;
          state <= ST_FIN;
        end
        ST_CP_RD: begin
          byte_buf <= mem_rdata;
          mem_addr <= dst;
          we_q     <= 1'b1;
          state    <= ST_CP_WR;
        end
        ST_CP_WR: begin
          we_q <= 1'b0;
          src  <= src + 1'b1;
          dst  <= dst + 1'b1;
          rem  <= rem - 1'b1;
          if (rem == LW'(1)) begin
            done  <= 1'b1;
            state <= ST_FIN;
          end else begin
            // Next read comes from the already-advanced source byte.
            mem_addr <= src + 1'b1;
            state    <= ST_CP_RD;
          end
        end
`ifdef MAU_FILL_EN
        ST_FILL: begin
          mem_addr <= mem_addr + 1'b1;
          rem      <= rem - 1'b1;
          if (rem == LW'(1)) begin
            we_q  <= 1'b0;
            done  <= 1'b1;
            state <= ST_FIN;
          end
        end
`endif
        ST_FIN: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          we_q      <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
